// File: rtl/uart_loader.sv
// Frame decoder behind the UART receiver: turns framed write commands into 32-bit
// word writes, drives the CPU hold line, and reports frame errors.
module uart_loader #(
    parameter int unsigned CLK_FRE       = 50,
    parameter int unsigned TIMEOUT_US    = 1000,
    parameter bit          HOLD_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err,
    output logic [2:0]  err_code,
    output logic [2:0]  dbg_state
);

    // Handshakes: a byte is consumed on any cycle with rx_valid while rx_ready is high;
    // mem_req/mem_addr/mem_wdata hold until a cycle with mem_req & mem_ack, req drops next cycle.

    localparam logic [31:0] TO        = 32'(CLK_FRE * TIMEOUT_US);
    localparam logic [7:0]  SOF       = 8'hA5;
    localparam logic [7:0]  CMD_WRITE = 8'h01;
    localparam logic [7:0]  CMD_RUN   = 8'h02;
    localparam logic [7:0]  CMD_HALT  = 8'h03;
    localparam logic [2:0]  ERR_NONE  = 3'd0;
    localparam logic [2:0]  ERR_CMD   = 3'd1;
    localparam logic [2:0]  ERR_OVR   = 3'd2;
    localparam logic [2:0]  ERR_CSUM  = 3'd3;
    localparam logic [2:0]  ERR_TMO   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR_H, S_ADDR_L, S_LEN, S_DATA, S_CSUM, S_DRAIN
    } state_t;

    state_t      state_q;
    logic [7:0]  cmd_q;
    logic [7:0]  xor_q;
    logic [15:0] addr_q;
    logic [8:0]  wcnt_q;
    logic [1:0]  idx_q;
    logic [31:0] word_q;
    logic [31:0] tmo_cnt_q;
    logic [31:0] tmo_cnt_d;
    logic        tmo_active;
    logic        tmo_hit;
    logic        mem_req_q;
    logic [15:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        cpu_hold_q;
    logic        load_done_q;
    logic        load_err_q;
    logic [2:0]  err_code_q;

    // A byte arriving in the same cycle as the threshold wins over the timeout.
    always_comb begin
        tmo_active = (state_q != S_IDLE) && (state_q != S_DRAIN);
        tmo_cnt_d  = (rx_valid || !tmo_active) ? 32'd0 : tmo_cnt_q + 32'd1;
        tmo_hit    = tmo_active && !rx_valid && (tmo_cnt_q == TO - 32'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            xor_q       <= '0;
            addr_q      <= '0;
            wcnt_q      <= '0;
            idx_q       <= '0;
            word_q      <= '0;
            tmo_cnt_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= HOLD_ON_RESET;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            tmo_cnt_q   <= tmo_cnt_d;
            if (mem_req_q && mem_ack) mem_req_q <= 1'b0;
            case (state_q)
                S_IDLE: if (rx_valid && rx_data == SOF) begin
                    state_q    <= S_CMD;
                    xor_q      <= '0;
                    err_code_q <= ERR_NONE;
                end
                S_CMD: if (rx_valid) begin
                    xor_q <= xor_q ^ rx_data;
                    cmd_q <= rx_data;
                    if (rx_data == CMD_WRITE) begin
                        state_q <= S_ADDR_H;
                    end else if (rx_data == CMD_RUN || rx_data == CMD_HALT) begin
                        state_q <= S_CSUM;
                    end else begin
                        state_q    <= S_IDLE;
                        err_code_q <= ERR_CMD;
                        load_err_q <= 1'b1;
                    end
                end
                S_ADDR_H: if (rx_valid) begin
                    xor_q        <= xor_q ^ rx_data;
                    addr_q[15:8] <= rx_data;
                    state_q      <= S_ADDR_L;
                end
                S_ADDR_L: if (rx_valid) begin
                    xor_q       <= xor_q ^ rx_data;
                    addr_q[7:0] <= rx_data;
                    state_q     <= S_LEN;
                end
                S_LEN: if (rx_valid) begin
                    xor_q   <= xor_q ^ rx_data;
                    wcnt_q  <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                    idx_q   <= 2'd0;
                    state_q <= S_DATA;
                end
                S_DATA: if (rx_valid) begin
                    xor_q  <= xor_q ^ rx_data;
                    word_q <= {rx_data, word_q[31:8]};
                    idx_q  <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        if (mem_req_q) begin
                            state_q    <= S_IDLE;
                            err_code_q <= ERR_OVR;
                            load_err_q <= 1'b1;
                        end else begin
                            mem_req_q   <= 1'b1;
                            mem_addr_q  <= addr_q;
                            mem_wdata_q <= {rx_data, word_q[31:8]};
                            addr_q      <= addr_q + 16'd1;
                            wcnt_q      <= wcnt_q - 9'd1;
                            if (wcnt_q == 9'd1) state_q <= S_CSUM;
                        end
                    end
                end
                S_CSUM: if (rx_valid) begin
                    if (rx_data != xor_q) begin
                        state_q    <= S_IDLE;
                        err_code_q <= ERR_CSUM;
                        load_err_q <= 1'b1;
                    end else if (cmd_q == CMD_WRITE) begin
                        state_q <= S_DRAIN;
                    end else begin
                        cpu_hold_q  <= (cmd_q == CMD_HALT);
                        load_done_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                S_DRAIN: if (!mem_req_q) begin
                    load_done_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
            if (tmo_hit) begin
                state_q    <= S_IDLE;
                err_code_q <= ERR_TMO;
                load_err_q <= 1'b1;
            end
        end
    end

    assign rx_ready  = (state_q != S_DRAIN);
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;
    assign err_code  = err_code_q;
    assign dbg_state = state_q;

endmodule
